// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values understood by the ALU and the
// state encoding of the sharing arbiter's FSM.
package alu_pkg;

  localparam logic [3:0] ALU_SLL    = 4'd0;
  localparam logic [3:0] ALU_SRL    = 4'd1;
  localparam logic [3:0] ALU_SRA    = 4'd2;
  localparam logic [3:0] ALU_PASS_A = 4'd3;
  localparam logic [3:0] ALU_PASS_B = 4'd4;
  localparam logic [3:0] ALU_ADD    = 4'd5;
  localparam logic [3:0] ALU_SUB    = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_XOR    = 4'd9;
  localparam logic [3:0] ALU_NOR    = 4'd10;
  localparam logic [3:0] ALU_SLT    = 4'd11;
  localparam logic [3:0] ALU_SLTU   = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request and response channels between the two ALU users and the arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int DATA_BITS = 32,
  parameter int OP_BITS   = 4
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic [OP_BITS-1:0]   req0_op;
  logic [DATA_BITS-1:0] req0_x;
  logic [DATA_BITS-1:0] req0_y;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [OP_BITS-1:0]   req1_op;
  logic [DATA_BITS-1:0] req1_x;
  logic [DATA_BITS-1:0] req1_y;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [DATA_BITS-1:0] rsp_result;
  logic [DATA_BITS-1:0] rsp_result_2;
  logic                 rsp_equal;
  logic                 rsp_smaller;

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_result_2, rsp_equal, rsp_smaller
  );

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_result_2, rsp_equal, rsp_smaller
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_grant;

  // Combinational winner selection, only meaningful while enabled.
  always_comb begin
    grant_valid = enable && (req_valid != 2'b00);
    grant_id    = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
  end

  // Remember the most recent winner so ties alternate; starts at 1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the CPU auxiliary path (id 0) and the physics engine
// (id 1). An accepted operation is registered onto the ALU inputs, the ALU
// outputs are captured one cycle later and held on the response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int OP_BITS   = 4
) (
  input  logic [4:0]           LOGISIM_CLOCK_TREE_0,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus,
  output logic [OP_BITS-1:0]   alu_op,
  output logic [DATA_BITS-1:0] alu_x,
  output logic [DATA_BITS-1:0] alu_y,
  input  logic [DATA_BITS-1:0] alu_result,
  input  logic [DATA_BITS-1:0] alu_result_2,
  input  logic                 alu_equal,
  input  logic                 alu_smaller,
  output logic                 busy
);

  logic   clk;
  logic   unused_clock_bits;
  state_t state;
  state_t next_state;
  logic   grant_valid;
  logic   grant_id;
  logic   cur_id;

  assign clk               = LOGISIM_CLOCK_TREE_0[4];
  assign unused_clock_bits = ^LOGISIM_CLOCK_TREE_0[3:0];
  assign busy              = (state != IDLE);

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_valid   ({bus.req1_valid, bus.req0_valid}),
    .enable      (state == IDLE),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state and ready handshake: requesters are only accepted while idle.
  always_comb begin
    next_state     = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state     = ISSUE;
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
        end
      end
      ISSUE:   next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand registers and response capture; ALU inputs hold until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op           <= '0;
      alu_x            <= '0;
      alu_y            <= '0;
      cur_id           <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_result_2 <= '0;
      bus.rsp_equal    <= 1'b0;
      bus.rsp_smaller  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_op <= grant_id ? bus.req1_op : bus.req0_op;
            alu_x  <= grant_id ? bus.req1_x  : bus.req0_x;
            alu_y  <= grant_id ? bus.req1_y  : bus.req0_y;
            cur_id <= grant_id;
          end
        end
        ISSUE: begin
          bus.rsp_result   <= alu_result;
          bus.rsp_result_2 <= alu_result_2;
          bus.rsp_equal    <= alu_equal;
          bus.rsp_smaller  <= alu_smaller;
          bus.rsp_id       <= cur_id;
          bus.rsp_valid    <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DATA_BITS = 32;
  localparam int OP_BITS   = 4;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] result;
    logic        equal;
    logic        smaller;
  } vec_t;

  logic [4:0]  clock_tree = 5'b0;
  logic        clk;
  logic        reset;
  logic [3:0]  alu_op;
  logic [31:0] alu_x, alu_y, alu_result, alu_result_2;
  logic        alu_equal, alu_smaller, busy;
  int          n_compared = 0;
  int          n_mismatched = 0;
  vec_t        vecs[8];

  assign clk = clock_tree[4];

  alu_share_arbiter_if #(.DATA_BITS(DATA_BITS), .OP_BITS(OP_BITS)) bus ();

  alu_share_arbiter #(.DATA_BITS(DATA_BITS), .OP_BITS(OP_BITS)) dut (
    .LOGISIM_CLOCK_TREE_0 (clock_tree),
    .reset                (reset),
    .bus                  (bus),
    .alu_op               (alu_op),
    .alu_x                (alu_x),
    .alu_y                (alu_y),
    .alu_result           (alu_result),
    .alu_result_2         (alu_result_2),
    .alu_equal            (alu_equal),
    .alu_smaller          (alu_smaller),
    .busy                 (busy)
  );

  // Free-running global clock on bit 4 of the clock tree.
  always #5 clock_tree[4] = ~clock_tree[4];

  function automatic logic [31:0] ref_result(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    case (op)
      ALU_SLL:    return x << y[4:0];
      ALU_SRL:    return x >> y[4:0];
      ALU_SRA:    return 32'($signed(x) >>> y[4:0]);
      ALU_PASS_A: return x;
      ALU_PASS_B: return y;
      ALU_ADD:    return x + y;
      ALU_SUB:    return x - y;
      ALU_AND:    return x & y;
      ALU_OR:     return x | y;
      ALU_XOR:    return x ^ y;
      ALU_NOR:    return ~(x | y);
      ALU_SLT:    return {31'b0, ($signed(x) < $signed(y))};
      ALU_SLTU:   return {31'b0, (x < y)};
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_result_2(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    return {x[15:0], y[15:0]} ^ {28'b0, op};
  endfunction

  function automatic logic ref_equal(logic [31:0] x, logic [31:0] y);
    return x == y;
  endfunction

  function automatic logic ref_smaller(logic [31:0] x, logic [31:0] y);
    return $signed(x) < $signed(y);
  endfunction

  // Stand-in for the real ALU, driven by the arbiter's registered operands.
  always_comb begin
    alu_result   = ref_result(alu_op, alu_x, alu_y);
    alu_result_2 = ref_result_2(alu_op, alu_x, alu_y);
    alu_equal    = ref_equal(alu_x, alu_y);
    alu_smaller  = ref_smaller(alu_x, alu_y);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_x = x; bus.req0_y = y;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_x = x; bus.req1_y = y;
    end
  endtask

  task automatic dropRequest(input int id);
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Waits for a grant in the current IDLE cycle, then follows the op through ISSUE and RESP.
  task automatic serveOne(input vec_t v, input bit redrive, input int bp);
    int got;
    got = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus.req0_ready) begin got = 0; break; end
      if (bus.req1_ready) begin got = 1; break; end
      @(negedge clk); #1;
    end
    checkOutput("grant_id", got, v.id);
    checkOutput("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 0);
    if (got < 0) return;
    @(negedge clk);
    if (!redrive) dropRequest(got);
    #1;
    checkOutput("issue_busy", 32'(busy), 1);
    checkOutput("issue_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("issue_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
    checkOutput("issue_alu_op", 32'(alu_op), 32'(v.op));
    @(negedge clk); #1;
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 1);
    checkOutput("rsp_id", 32'(bus.rsp_id), v.id);
    checkOutput("rsp_result", bus.rsp_result, v.result);
    checkOutput("rsp_result_2", bus.rsp_result_2, ref_result_2(v.op, v.x, v.y));
    checkOutput("rsp_equal", 32'(bus.rsp_equal), 32'(v.equal));
    checkOutput("rsp_smaller", 32'(bus.rsp_smaller), 32'(v.smaller));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk); #1;
      checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      checkOutput("hold_rsp_id", 32'(bus.rsp_id), v.id);
      checkOutput("hold_rsp_result", bus.rsp_result, v.result);
      checkOutput("hold_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
      checkOutput("hold_alu_x", alu_x, v.x);
      checkOutput("hold_alu_y", alu_y, v.y);
      checkOutput("hold_busy", 32'(busy), 1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("done_rsp_valid", 32'(bus.rsp_valid), 0);
  endtask

  // Safety net so the bench always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vec_t v0, v1, fa, fb;
    int   got;
    bit   seen;
    int   m_last, m_wait, acc, g;
    bit   m_inflight, consumed, rdy;
    vec_t m_exp;
    bit          rv[2];
    logic [3:0]  rop[2];
    logic [31:0] rx[2], ry[2];

    vecs[0] = '{0, ALU_ADD,  32'd7,          32'd3,          32'd10,         1'b0, 1'b0};
    vecs[1] = '{1, ALU_SLT,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b1};
    vecs[2] = '{1, ALU_SLTU, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b1};
    vecs[3] = '{0, ALU_AND,  32'hF0,         32'hFF,         32'hF0,         1'b0, 1'b1};
    vecs[4] = '{1, 4'd13,    32'd5,          32'd5,          32'd0,          1'b1, 1'b0};
    vecs[5] = '{0, ALU_SLL,  32'd1,          32'd31,         32'h80000000,   1'b0, 1'b1};
    vecs[6] = '{1, ALU_SRA,  32'h80000000,   32'd4,          32'hF8000000,   1'b0, 1'b1};
    vecs[7] = '{0, ALU_SUB,  32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1'b1};

    bus.req0_op = '0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_op = '0; bus.req1_x = '0; bus.req1_y = '0;
    doReset();

    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 0);
    checkOutput("reset_rsp_result", bus.rsp_result, 0);
    checkOutput("reset_rsp_result_2", bus.rsp_result_2, 0);
    checkOutput("reset_rsp_flags", 32'({bus.rsp_equal, bus.rsp_smaller}), 0);
    checkOutput("reset_alu_op", 32'(alu_op), 0);
    checkOutput("reset_alu_x", alu_x, 0);
    checkOutput("reset_alu_y", alu_y, 0);
    checkOutput("reset_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].id, vecs[i].op, vecs[i].x, vecs[i].y);
      #1;
      serveOne(vecs[i], 1'b0, 0);
    end

    $display("[TB] contention after reset");
    doReset();
    v0 = '{0, ALU_SUB, 32'd10,  32'd4,  32'd6,  1'b0, 1'b0};
    v1 = '{1, ALU_XOR, 32'hF0,  32'hFF, 32'h0F, 1'b0, 1'b1};
    applyStimulus(0, v0.op, v0.x, v0.y);
    applyStimulus(1, v1.op, v1.x, v1.y);
    #1;
    serveOne(v0, 1'b0, 0);
    serveOne(v1, 1'b0, 0);

    $display("[TB] fairness under continuous contention");
    fa = '{0, ALU_ADD, 32'd1,   32'd2, 32'd3,    1'b0, 1'b1};
    fb = '{1, ALU_OR,  32'h10,  32'd1, 32'h11,   1'b0, 1'b0};
    applyStimulus(0, fa.op, fa.x, fa.y);
    applyStimulus(1, fb.op, fb.x, fb.y);
    #1;
    for (int k = 0; k < 6; k++) serveOne((k % 2 == 0) ? fa : fb, 1'b1, 0);
    dropRequest(0);
    dropRequest(1);

    $display("[TB] response backpressure");
    v0 = '{0, ALU_PASS_A, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 1'b0, 1'b0};
    applyStimulus(0, v0.op, v0.x, v0.y);
    #1;
    serveOne(v0, 1'b0, 4);

    $display("[TB] reset while issuing");
    applyStimulus(0, ALU_ADD, 32'd1, 32'd1);
    #1;
    got = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus.req0_ready) begin got = 0; break; end
      @(negedge clk); #1;
    end
    checkOutput("rst_accept", got, 0);
    @(negedge clk);
    dropRequest(0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clk); #1;
    end
    checkOutput("rst_no_response", 32'(seen), 0);
    v0 = '{0, ALU_AND, 32'hC, 32'hA, 32'h8, 1'b0, 1'b0};
    v1 = '{1, ALU_SUB, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0};
    applyStimulus(0, v0.op, v0.x, v0.y);
    applyStimulus(1, v1.op, v1.x, v1.y);
    #1;
    checkOutput("rst_first_grant", 32'(bus.req0_ready), 1);
    serveOne(v0, 1'b0, 0);
    serveOne(v1, 1'b0, 0);

    $display("[TB] randomized traffic");
    doReset();
    m_last = 1; m_wait = 0; m_inflight = 1'b0; acc = -1; consumed = 1'b0;
    m_exp = '{0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; rop[i] = '0; rx[i] = '0; ry[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (m_inflight) begin
        if (m_wait == 0) begin
          if (consumed) m_inflight = 1'b0;
        end else begin
          m_wait--;
        end
      end else if (acc >= 0) begin
        m_inflight = 1'b1;
        m_wait = 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (acc == i) rv[i] = 1'b0;
        if (!rv[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            rv[i]  = 1'b1;
            rop[i] = 4'($urandom_range(15, 0));
            rx[i]  = $urandom;
            ry[i]  = ($urandom_range(3, 0) == 0) ? rx[i] : $urandom;
          end
        end else if ($urandom_range(7, 0) == 0) begin
          rv[i] = 1'b0;
        end
        if (rv[i]) applyStimulus(i, rop[i], rx[i], ry[i]);
        else       dropRequest(i);
      end
      rdy = 1'($urandom_range(1, 0));
      bus.rsp_ready = rdy;
      #1;
      g = -1;
      if (!m_inflight) begin
        if (rv[0] && rv[1]) g = 1 - m_last;
        else if (rv[0])     g = 0;
        else if (rv[1])     g = 1;
      end
      checkOutput("rnd_ready0", 32'(bus.req0_ready), 32'(g == 0));
      checkOutput("rnd_ready1", 32'(bus.req1_ready), 32'(g == 1));
      checkOutput("rnd_busy", 32'(busy), 32'(m_inflight));
      checkOutput("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(m_inflight && m_wait == 0));
      if (m_inflight && m_wait == 0) begin
        checkOutput("rnd_rsp_id", 32'(bus.rsp_id), m_exp.id);
        checkOutput("rnd_rsp_result", bus.rsp_result, ref_result(m_exp.op, m_exp.x, m_exp.y));
        checkOutput("rnd_rsp_result_2", bus.rsp_result_2, ref_result_2(m_exp.op, m_exp.x, m_exp.y));
        checkOutput("rnd_rsp_equal", 32'(bus.rsp_equal), 32'(ref_equal(m_exp.x, m_exp.y)));
        checkOutput("rnd_rsp_smaller", 32'(bus.rsp_smaller), 32'(ref_smaller(m_exp.x, m_exp.y)));
      end
      consumed = m_inflight && (m_wait == 0) && rdy;
      acc = g;
      if (g >= 0) begin
        m_last = g;
        m_exp  = '{g, rop[g], rx[g], ry[g], 32'd0, 1'b0, 1'b0};
      end
    end
    dropRequest(0);
    dropRequest(1);
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
